// File: rtl/int_calc_seq.sv
// int_calc_seq: sequential-entry integer calculator with iterative multiply/divide
module int_calc_seq #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] switches,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             sign,
  output logic             ready,
  output logic             busy,
  output logic             overflow,
  output logic             underflow,
  output logic             inexact,
  output logic             invalid,
  output logic             exception
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {GET_A, GET_B, EXEC, DONE} state_t;
  state_t r_state, w_next;
  logic r_en_d, r_ovf, r_unf, r_inx, r_inv;
  logic [W-1:0] r_a, r_b, r_rem, r_q, r_result;
  logic [1:0] r_op;
  logic [CW-1:0] r_cnt;
  logic [2*W-1:0] r_p;
  logic w_edge, w_neg, w_iter, w_last, w_fin, w_mbit, w_dbit, w_ge, w_fit;
  logic w_ovf, w_unf, w_inx, w_inv;
  logic [W-1:0] w_ma, w_mb, w_diff, w_quo, w_res;
  logic [W:0] w_xa, w_xb, w_sum, w_trial;
  logic [2*W-1:0] w_prod;
  assign w_edge  = enable && !r_en_d;
  assign w_ma    = (SIGNED && r_a[W-1]) ? -r_a : r_a;
  assign w_mb    = (SIGNED && r_b[W-1]) ? -r_b : r_b;
  assign w_neg   = SIGNED && (r_a[W-1] ^ r_b[W-1]);
  assign w_xa    = {SIGNED && r_a[W-1], r_a};
  assign w_xb    = {SIGNED && r_b[W-1], r_b};
  assign w_sum   = r_op[0] ? w_xa - w_xb : w_xa + w_xb;
  assign w_iter  = r_op[1] && !(r_op[0] && ~|r_b);
  assign w_last  = r_cnt == CW'(W);
  assign w_fin   = !w_iter || w_last;
  assign w_mbit  = |(w_mb & ({{(W-1){1'b0}}, 1'b1} << r_cnt));
  assign w_dbit  = |(w_ma & ({1'b1, {(W-1){1'b0}}} >> r_cnt));
  assign w_trial = {r_rem, w_dbit};
  assign w_ge    = w_trial >= {1'b0, w_mb};
  assign w_diff  = w_trial[W-1:0] - w_mb;
  assign w_prod  = w_neg ? -r_p : r_p;
  assign w_quo   = w_neg ? -r_q : r_q;
  assign w_fit   = (&w_prod[2*W-1:W-1]) || !(|w_prod[2*W-1:W-1]);
  // Result and flags for whichever operation is finishing this cycle
  always_comb begin
    w_res = w_sum[W-1:0];
    w_ovf = SIGNED ? (!w_sum[W] && w_sum[W-1]) : (!r_op[0] && w_sum[W]);
    w_unf = SIGNED ? (w_sum[W] && !w_sum[W-1]) : (r_op[0] && w_sum[W]);
    w_inx = 1'b0;
    w_inv = 1'b0;
    if (r_op == 2'b10) begin
      w_res = w_prod[W-1:0];
      w_ovf = SIGNED ? (!w_fit && !w_neg) : |r_p[2*W-1:W];
      w_unf = SIGNED && !w_fit && w_neg;
    end else if (r_op == 2'b11) begin
      w_inv = ~|r_b;
      w_res = w_inv ? '0 : w_quo;
      w_ovf = !w_inv && SIGNED && !w_neg && r_q[W-1];
      w_unf = 1'b0;
      w_inx = !w_inv && |r_rem;
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      GET_A, DONE: w_next = w_edge ? GET_B : r_state;
      GET_B:       w_next = w_edge ? EXEC : GET_B;
      EXEC:        w_next = w_fin ? DONE : EXEC;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) r_state <= GET_A;
    else r_state <= w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_d   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inx    <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      r_en_d <= enable;
      if (w_edge && (r_state == GET_A || r_state == DONE)) begin
        r_a   <= switches;
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
        r_inx <= 1'b0;
        r_inv <= 1'b0;
      end
      if (w_edge && r_state == GET_B) begin
        r_b   <= switches;
        r_op  <= op;
        r_cnt <= '0;
        r_p   <= '0;
        r_rem <= '0;
        r_q   <= '0;
      end
      if (r_state == EXEC) begin
        if (w_fin) begin
          r_result <= w_res;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_inx    <= w_inx;
          r_inv    <= w_inv;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          r_p   <= w_mbit ? r_p + ({{W{1'b0}}, w_ma} << r_cnt) : r_p;
          r_rem <= w_ge ? w_diff : w_trial[W-1:0];
          r_q   <= {r_q[W-2:0], w_ge};
        end
      end
    end
  end
  assign result    = r_result;
  assign sign      = SIGNED ? r_result[W-1] : 1'b0;
  assign ready     = r_state == DONE;
  assign busy      = r_state == EXEC;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign inexact   = r_inx;
  assign invalid   = r_inv;
  assign exception = r_ovf || r_unf || r_inv;
endmodule

// File: tb/tb_int_calc_seq.sv
// tb_int_calc_seq: scoreboard bench for a 16-bit signed and an 8-bit unsigned calculator
module tb_int_calc_seq;
  logic clk = 0, rst = 1, en16 = 0, en8 = 0;
  logic [15:0] sw = '0;
  logic [1:0] op = '0;
  logic [15:0] res16;
  logic [7:0] res8;
  logic sg16, rdy16, bsy16, ov16, un16, ix16, iv16, ex16;
  logic sg8, rdy8, bsy8, ov8, un8, ix8, iv8, ex8;
  logic [5:0] f16, f8;
  logic [21:0] q16[$], q8[$];
  logic [21:0] e16, e8;
  logic rd16 = 0, rd8 = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  int_calc_seq #(.WIDTH(16), .SIGNED(1)) u16 (
    .clk(clk), .rst(rst), .enable(en16), .switches(sw), .op(op), .result(res16), .sign(sg16),
    .ready(rdy16), .busy(bsy16), .overflow(ov16), .underflow(un16), .inexact(ix16),
    .invalid(iv16), .exception(ex16));
  int_calc_seq #(.WIDTH(8), .SIGNED(0)) u8 (
    .clk(clk), .rst(rst), .enable(en8), .switches(sw[7:0]), .op(op), .result(res8), .sign(sg8),
    .ready(rdy8), .busy(bsy8), .overflow(ov8), .underflow(un8), .inexact(ix8),
    .invalid(iv8), .exception(ex8));
  assign f16 = {sg16, ov16, un16, ix16, iv16, ex16};
  assign f8  = {sg8, ov8, un8, ix8, iv8, ex8};
  // Monitor: pop one expectation per rising ready
  always @(negedge clk) begin
    rd16 <= rdy16;
    rd8  <= rdy8;
    if (rdy16 && bsy16) begin errors++; $display("FAIL overlap16 busy and ready both 1, required exclusive"); end
    if (rdy8 && bsy8) begin errors++; $display("FAIL overlap8 busy and ready both 1, required exclusive"); end
    if (rdy16 && !rd16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL sb16 unexpected result %h flags %b, required no output", res16, f16);
      end else begin
        e16 = q16.pop_front();
        if ({res16, f16} !== e16) begin
          errors++;
          $display("FAIL sb16 result %h flags %b, required %h flags %b", res16, f16, e16[21:6], e16[5:0]);
        end
      end
    end
    if (rdy8 && !rd8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL sb8 unexpected result %h flags %b, required no output", res8, f8);
      end else begin
        e8 = q8.pop_front();
        if ({8'h00, res8, f8} !== e8) begin
          errors++;
          $display("FAIL sb8 result %h flags %b, required %h flags %b", res8, f8, e8[21:6], e8[5:0]);
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask
  task automatic pulse(input bit s, input logic [15:0] v, input logic [1:0] o);
    @(negedge clk);
    sw = v;
    op = o;
    if (s) en8 = 1; else en16 = 1;
    @(negedge clk);
    en8  = 0;
    en16 = 0;
  endtask
  task automatic finish_op(input bit s, input logic [15:0] r, input logic [5:0] f,
                           input int lat, input bit wig, input string name);
    int n = 0, bc = 0;
    if (s) q8.push_back({r, f}); else q16.push_back({r, f});
    while (!(s ? rdy8 : rdy16) && n < 100) begin
      if (s ? bsy8 : bsy16) bc++;
      @(negedge clk);
      n++;
      if (wig) en16 = (n < lat - 3) && n[0];
    end
    en16 = 0;
    check({name, " latency"}, n, lat);
    check({name, " busy cycles"}, bc, lat);
  endtask
  task automatic calc(input bit s, input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                      input logic [15:0] r, input logic [5:0] f, input int lat, input string name);
    pulse(s, a, 2'b00);
    pulse(s, b, o);
    finish_op(s, r, f, lat, 0, name);
  endtask
  // Flag vector order: {sign, overflow, underflow, inexact, invalid, exception}
  initial begin
    repeat (2) @(negedge clk);
    check("reset res16", res16, 0);
    check("reset flags16", {rdy16, bsy16, f16}, 0);
    check("reset res8/flags8", {rdy8, bsy8, res8, f8}, 0);
    rst = 0;
    calc(0, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 6'b110001, 1, "add ovf");
    calc(0, 16'h8000, 16'h0001, 2'b01, 16'h7FFF, 6'b001001, 1, "sub unf");
    pulse(0, 16'hFFFD, 2'b00);
    check("chain ready/busy", {rdy16, bsy16}, 0);
    check("chain flags clear", {ov16, un16, ix16, iv16, ex16}, 0);
    pulse(0, 16'h0005, 2'b10);
    finish_op(0, 16'hFFF1, 6'b100000, 17, 1, "mul neg");
    calc(0, 16'h0100, 16'h0100, 2'b10, 16'h0000, 6'b010001, 17, "mul ovf");
    calc(0, 16'h0007, 16'hFFFE, 2'b11, 16'hFFFD, 6'b100100, 17, "div inexact");
    calc(0, 16'h8000, 16'hFFFF, 2'b11, 16'h8000, 6'b110001, 17, "div min/-1");
    pulse(0, 16'h0003, 2'b00);
    pulse(0, 16'h0005, 2'b10);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("abort res16", res16, 0);
    check("abort state", {rdy16, bsy16, f16}, 0);
    en16 = 1;
    sw = 16'h0010;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    sw = 16'h0020;
    repeat (3) @(negedge clk);
    check("held enable single capture", {rdy16, bsy16}, 0);
    en16 = 0;
    pulse(0, 16'h0001, 2'b00);
    finish_op(0, 16'h0011, 6'b000000, 1, 0, "held add");
    calc(0, 16'h0005, 16'h0000, 2'b11, 16'h0000, 6'b000011, 1, "div zero");
    calc(1, 16'h0003, 16'h0005, 2'b01, 16'h00FE, 6'b001001, 1, "u sub");
    calc(1, 16'h0010, 16'h0010, 2'b10, 16'h0000, 6'b010001, 9, "u mul");
    calc(1, 16'h00C8, 16'h0007, 2'b11, 16'h001C, 6'b000100, 9, "u div");
    calc(1, 16'h00FF, 16'h0001, 2'b00, 16'h0000, 6'b010001, 1, "u add carry");
    repeat (3) @(negedge clk);
    check("sb16 drained", q16.size(), 0);
    check("sb8 drained", q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/int_calc_seq.md
# int_calc_seq

Parametrised, multi-cycle integer calculator for the board's switch/button front end. It is the next generation of the 16-bit `top` calculator, with these additions:
- generic operand width and signed/unsigned mode;
- operands and opcode entered sequentially through one `enable` strobe;
- iterative shift-add multiply and restoring divide;
- a `busy`/`ready` handshake and the same flag set as before.

## Interface
- `WIDTH`, 16: operand/result width in bits; legal values are 4 to 32.
- `SIGNED`, 1: 1 selects two's-complement arithmetic, 0 selects unsigned.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  entry strobe; the block acts only on its rising edge (high now, low in the previous cycle).
- `switches`  in  WIDTH  operand value.
- `op`  in  2  opcode, sampled together with operand B: 00 add, 01 sub, 10 mul, 11 div.
- `result`  out  WIDTH  registered result.
- `sign`  out  1  equals `result[WIDTH-1]` when `SIGNED`=1; always 0 when `SIGNED`=0.
- `ready`  out  1  `result` and flags are valid.
- `busy`  out  1  a computation is in progress.
- `overflow`  out  1  true result is above the representable maximum.
- `underflow`  out  1  true result is below the representable minimum (unsigned: negative).
- `inexact`  out  1  divide left a nonzero remainder.
- `invalid`  out  1  divide by zero.
- `exception`  out  1  OR of `overflow`, `underflow` and `invalid`.

## Operation
State machine states: GET_A, GET_B, EXEC, DONE.

- **Reset:** forces GET_A and clears all outputs, the operand registers and the enable-edge register.
  - Because the edge register clears, an `enable` held high across reset release counts as one edge.
- **GET_A:** an edge captures `switches` into A and moves to GET_B.
- **GET_B:** an edge captures `switches` into B and `op` into the opcode, then moves to EXEC. `busy` rises.
- **EXEC:** `enable` edges are ignored.
  - Add and sub take 1 cycle.
  - Div with B=0 takes 1 cycle: `result`=0, `invalid`=1, no iteration.
  - Mul: WIDTH-iteration shift-add on magnitudes, forming a 2·WIDTH-bit product, then sign correction.
  - Div: WIDTH-iteration restoring divide on magnitudes. The quotient truncates toward zero; the remainder is used only for `inexact`.
  - On completion: `result`, `sign` and flags are registered, `busy` falls, `ready` rises, and the state moves to DONE.
- **DONE:** outputs are held. An edge captures `switches` as the new A, clears `ready` and all flags, and moves to GET_B (chained entry without returning to GET_A).

Arithmetic rules:
- `result` is always the low WIDTH bits of the true result (wrap).
- **Add/sub, signed:** `overflow` if the true result is at or above 2^(WIDTH-1); `underflow` if it is below −2^(WIDTH-1).
- **Add/sub, unsigned:** `overflow` on carry out of add; `underflow` on borrow in sub.
- **Mul, signed:** if the product does not sign-fit in WIDTH bits, flag `overflow` for a positive product and `underflow` for a negative one.
- **Mul, unsigned:** `overflow` if the upper half of the product is nonzero.
- **Div, signed:** −2^(WIDTH-1) / −1 gives `result` = −2^(WIDTH-1) and `overflow`=1.
- **Div, unsigned:** never sets `overflow` or `underflow`.
- `inexact` is only ever set by div.

## Timing
- Edge detection adds no delay: A or B is captured at the same clock edge on which `enable` is first sampled high.
- Latency, counted from the edge that captures B to the edge that asserts `ready`:
  - add/sub: 1 cycle;
  - div by zero: 1 cycle;
  - mul/div: WIDTH+1 cycles (WIDTH iterations plus 1 finalise cycle).
- `busy` is high exactly while the state is EXEC. `ready` is high exactly while the state is DONE. The two are never high together.
- `ready` and flags stay stable until the next accepted edge or reset.
- Reset during EXEC aborts the operation. `busy` and `ready` are 0 on the next cycle, and nothing from the aborted operation is ever presented.
- Flags change only on the EXEC→DONE transition, on the DONE→GET_B clear, or on reset.

## Test plan
All scenarios use WIDTH=16, SIGNED=1 unless stated.

1. **Signed add overflow:** A=0x7FFF, B=0x0001, op=00 → `result`=0x8000, `sign`=1, `overflow`=1, `exception`=1. `ready` is high 1 cycle after B capture.
2. **Signed sub underflow, and chaining:** A=0x8000, B=0x0001, op=01 → 0x7FFF, `underflow`=1, `sign`=0.
   - A further edge in DONE captures a new A, clears `ready` and flags, and reaches GET_B.
3. **Multiply:**
   - A=0xFFFD (−3), B=0x0005, op=10 → 0xFFF1, `sign`=1, no flags. `busy` stays high for 17 cycles. Edges on `enable` during EXEC are ignored.
   - A=0x0100, B=0x0100 → 0x0000, `overflow`=1.
4. **Divide:**
   - 7 / 0xFFFE (−2) → 0xFFFD, `inexact`=1.
   - 0x8000 / 0xFFFF → 0x8000, `overflow`=1.
   - 5 / 0 → `result`=0, `invalid`=1, `exception`=1, `ready` high 1 cycle after B capture.
5. **Reset mid-operation:** assert `rst` 5 cycles into a mul → next cycle: GET_A, all outputs 0.
   - Hold `enable` high through reset release → exactly one A capture.
6. **Unsigned mode (WIDTH=8, SIGNED=0):**
   - 3 − 5 → 0xFE, `underflow`=1, `sign`=0.
   - 0x10 × 0x10 → 0x00, `overflow`=1.
   - 200 / 7 → 0x1C, `inexact`=1.
